// File: rtl/assoc_ctrl_pkg.sv
// Shared op codes and FSM states for the associative-buffer arbiter.
package assoc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LOAD = 2'd1,
    OP_INCR = 2'd2,
    OP_CLR  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = idx;
        grant     = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/assoc_buffer_arbiter.sv
// Round-robin arbiter sharing one associative buffer between NUM_REQ
// requesters over a 4-phase req/ack handshake with a registered response.
module assoc_buffer_arbiter
  import assoc_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int KEY_SIZE  = 4,
  parameter int DATA_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          sync_nreset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [KEY_SIZE*NUM_REQ-1:0]   req_key,
  input  logic [DATA_SIZE*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_SIZE-1:0]          rsp_data,
  output logic                          rsp_hit,
  output logic                          busy,
  output logic [1:0]                    buf_ctrl,
  output logic [KEY_SIZE-1:0]           buf_key,
  output logic [DATA_SIZE-1:0]          buf_data_in,
  input  logic [DATA_SIZE-1:0]          buf_data_out,
  input  logic                          buf_valid
);

  localparam int IW = $clog2(NUM_REQ);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        g;
  logic [NUM_REQ-1:0]   g_oh;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 any_req;
  logic [1:0]           sel_op;
  logic [KEY_SIZE-1:0]  sel_key;
  logic [DATA_SIZE-1:0] sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Payload of the winning requester, selected by shifting the flat buses.
  assign sel_op   = 2'(req_op >> (2 * grant_idx));
  assign sel_key  = KEY_SIZE'(req_key >> (KEY_SIZE * grant_idx));
  assign sel_data = DATA_SIZE'(req_data >> (DATA_SIZE * grant_idx));

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      state       <= ST_IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      g           <= '0;
      g_oh        <= '0;
      ack         <= '0;
      rsp_data    <= '0;
      rsp_hit     <= 1'b0;
      busy        <= 1'b0;
      buf_ctrl    <= OP_NONE;
      buf_key     <= '0;
      buf_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            g           <= grant_idx;
            g_oh        <= grant;
            buf_ctrl    <= sel_op;
            buf_key     <= sel_key;
            buf_data_in <= sel_data;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Buffer outputs here reflect the entry before this cycle's update.
          rsp_data <= buf_valid ? buf_data_out : '0;
          rsp_hit  <= buf_valid;
          ack      <= g_oh;
          ptr      <= g;
          buf_ctrl <= OP_NONE;
          state    <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (!req[g]) begin
            ack   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_buffer_arbiter.sv
// Scoreboard bench: transaction-level reference model predicts responses,
// a negedge monitor compares them whenever an ack rises.
module tb_assoc_buffer_arbiter;

  localparam int N   = 4;
  localparam int KS  = 4;
  localparam int DS  = 4;
  localparam int CAP = 4;

  logic            clk = 1'b0;
  logic            sync_nreset;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [KS*N-1:0] req_key;
  logic [DS*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic [DS-1:0]   rsp_data;
  logic            rsp_hit;
  logic            busy;
  logic [1:0]      buf_ctrl;
  logic [KS-1:0]   buf_key;
  logic [DS-1:0]   buf_data_in;
  logic [DS-1:0]   buf_data_out;
  logic            buf_valid;

  always #5 clk = ~clk;

  assoc_buffer_arbiter #(
    .NUM_REQ   (N),
    .KEY_SIZE  (KS),
    .DATA_SIZE (DS)
  ) dut (
    .clk          (clk),
    .sync_nreset  (sync_nreset),
    .req          (req),
    .req_op       (req_op),
    .req_key      (req_key),
    .req_data     (req_data),
    .ack          (ack),
    .rsp_data     (rsp_data),
    .rsp_hit      (rsp_hit),
    .busy         (busy),
    .buf_ctrl     (buf_ctrl),
    .buf_key      (buf_key),
    .buf_data_in  (buf_data_in),
    .buf_data_out (buf_data_out),
    .buf_valid    (buf_valid)
  );

  // Associative buffer stub: an access happens when ctrl is not NONE or the
  // key changes; hits apply the op, misses allocate a free slot if any.
  logic          bm_v [CAP];
  logic [KS-1:0] bm_k [CAP];
  logic [DS-1:0] bm_d [CAP];
  logic [KS-1:0] bm_last;
  int            bm_hit, bm_free;

  function automatic logic [DS-1:0] bm_next(logic [1:0] op, logic [DS-1:0] old, logic [DS-1:0] din);
    case (op)
      2'd1:    return din;
      2'd2:    return old + 1'b1;
      2'd3:    return '0;
      default: return old;
    endcase
  endfunction

  always_comb begin
    buf_valid    = 1'b0;
    buf_data_out = '0;
    bm_hit       = -1;
    bm_free      = -1;
    for (int i = 0; i < CAP; i++) begin
      if (bm_v[i] && bm_k[i] == buf_key && bm_hit < 0) begin
        bm_hit       = i;
        buf_valid    = 1'b1;
        buf_data_out = bm_d[i];
      end
      if (!bm_v[i] && bm_free < 0) bm_free = i;
    end
  end

  always @(posedge clk) begin
    if (!sync_nreset) begin
      for (int i = 0; i < CAP; i++) bm_v[i] <= 1'b0;
      bm_last <= '0;
    end else if (buf_ctrl != 2'd0 || buf_key != bm_last) begin
      bm_last <= buf_key;
      if (bm_hit >= 0) begin
        bm_d[bm_hit] <= bm_next(buf_ctrl, bm_d[bm_hit], buf_data_in);
      end else if (bm_free >= 0) begin
        bm_v[bm_free] <= 1'b1;
        bm_k[bm_free] <= buf_key;
        bm_d[bm_free] <= bm_next(buf_ctrl, '0, buf_data_in);
      end
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    int idx;
    int hit;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   mdl_store[int];
  int   mdl_last;
  int   mdl_ptr;
  int   pl_op[N], pl_key[N], pl_data[N];
  int   hold_cfg[N];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  logic [N-1:0] prev_ack;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    mdl_store.delete();
    mdl_last = 0;
    mdl_ptr  = N - 1;
  endfunction

  function automatic int model_next(int op, int old, int din);
    case (op)
      1:       return din;
      2:       return (old + 1) % (1 << DS);
      3:       return 0;
      default: return old;
    endcase
  endfunction

  function automatic void model_txn(int i);
    exp_t e;
    int   key = pl_key[i];
    bit   hit = mdl_store.exists(key);
    e.idx  = i;
    e.hit  = hit;
    e.data = hit ? mdl_store[key] : 0;
    if (pl_op[i] != 0 || key != mdl_last) begin
      if (hit) mdl_store[key] = model_next(pl_op[i], mdl_store[key], pl_data[i]);
      else if (mdl_store.num() < CAP) mdl_store[key] = model_next(pl_op[i], 0, pl_data[i]);
    end
    mdl_last = key;
    exp_q.push_back(e);
  endfunction

  // Grants cycle round-robin over the requesting set, starting after mdl_ptr.
  task automatic start_round(input logic [N-1:0] set, input int count);
    int p = mdl_ptr;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]    = 2'(pl_op[i]);
      req_key[KS*i +: KS] = KS'(pl_key[i]);
      req_data[DS*i +: DS] = DS'(pl_data[i]);
    end
    for (int t = 0; t < count; t++) begin
      for (int off = 1; off <= N; off++) begin
        if (set[(p + off) % N]) begin
          p = (p + off) % N;
          break;
        end
      end
      model_txn(p);
    end
    mdl_ptr = p;
    req = req | set;
  endtask

  // Completes count handshakes; the first count-nset served requesters re-raise.
  task automatic serve(input int count, input int nset);
    for (int t = 0; t < count; t++) begin
      int w = 0;
      int i = 0;
      while (ack == '0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (ack == '0) begin
        check("ack_timeout", 0, 1);
        req = '0;
        repeat (3) @(negedge clk);
        return;
      end
      for (int k = 0; k < N; k++) if (ack[k]) i = k;
      repeat (hold_cfg[i]) begin
        @(negedge clk);
        check("ack_hold", int'(ack), 1 << i);
        check("busy_hold", int'(busy), 1);
      end
      req[i] = 1'b0;
      @(negedge clk);
      check("ack_release", int'(ack), 0);
      if (t < count - nset) begin
        @(negedge clk);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic single(input int i, input int op, input int key, input int data);
    pl_op[i]   = op;
    pl_key[i]  = key;
    pl_data[i] = data;
    start_round(N'(1) << i, 1);
    serve(1, 1);
  endtask

  task automatic do_reset();
    sync_nreset = 1'b0;
    req         = '0;
    repeat (2) @(negedge clk);
    model_reset();
    sync_nreset = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!sync_nreset) begin
      prev_ack = '0;
    end else begin
      if (buf_ctrl != 2'd0) pulses++;
      if (ack != '0 && prev_ack == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          cur = exp_q.pop_front();
          check("ack_grant", int'(ack), 1 << cur.idx);
          check("rsp_hit", int'(rsp_hit), cur.hit);
          check("rsp_data", int'(rsp_data), cur.data);
        end
      end else if (ack != '0) begin
        check("rsp_stable", int'({rsp_hit, rsp_data}), (cur.hit << DS) | cur.data);
      end
      prev_ack = ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    sync_nreset = 1'b0;
    req         = '0;
    req_op      = '0;
    req_key     = '0;
    req_data    = '0;
    for (int i = 0; i < N; i++) begin
      pl_op[i] = 0; pl_data[i] = 0; hold_cfg[i] = 0;
    end
    model_reset();

    // Reset with all requesters pending, then release: requester 0 wins.
    pl_key[0] = 0; pl_key[1] = 5; pl_key[2] = 6; pl_key[3] = 7;
    start_round(4'b1111, 4);
    repeat (2) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_buf_ctrl", int'(buf_ctrl), 0);
    check("rst_buf_key", int'(buf_key), 0);
    check("rst_rsp", int'({rsp_hit, rsp_data}), 0);
    sync_nreset = 1'b1;
    @(negedge clk);
    check("lat1_ack", int'(ack), 0);
    check("lat1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat2_ack", int'(ack), 1);
    serve(4, 4);

    // LOAD / lookup / INCR / CLR on one key.
    do_reset();
    single(0, 1, 3, 5);
    single(0, 0, 3, 0);
    single(0, 2, 3, 0);
    single(0, 0, 3, 0);
    single(0, 3, 3, 0);
    single(0, 0, 3, 0);

    // Fairness over 1011 with re-raise; one buffer op pulse per grant.
    pl_op[0] = 2; pl_key[0] = 3;
    pl_op[1] = 2; pl_key[1] = 3;
    pl_op[3] = 1; pl_key[3] = 4; pl_data[3] = 9;
    p0 = pulses;
    start_round(4'b1011, 6);
    serve(6, 3);
    check("op_pulses", pulses - p0, 6);

    // Stall: requester 1 holds req after ack while requester 2 waits.
    single(3, 0, 4, 0);
    pl_op[1] = 0; pl_key[1] = 3;
    pl_op[2] = 0; pl_key[2] = 4;
    hold_cfg[1] = 10;
    start_round(4'b0110, 2);
    serve(2, 2);
    hold_cfg[1] = 0;

    // Full buffer: fifth key is dropped, existing keys keep their data.
    do_reset();
    for (int k = 1; k <= 4; k++) single(k % N, 1, k, k + 10);
    single(0, 1, 9, 7);
    for (int k = 1; k <= 4; k++) single((k + 1) % N, 0, k, 0);
    single(2, 0, 9, 0);

    // Randomised rounds.
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] set;
      int cnt;
      set = N'($urandom_range(1, (1 << N) - 1));
      cnt = $countones(set);
      for (int i = 0; i < N; i++) begin
        pl_op[i]    = $urandom_range(0, 3);
        pl_key[i]   = $urandom_range(0, 7);
        pl_data[i]  = $urandom_range(0, 15);
        hold_cfg[i] = $urandom_range(0, 3);
      end
      start_round(set, cnt);
      serve(cnt, cnt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_buffer_arbiter.md
Name: assoc_buffer_arbiter

Overview:
Shares one associative buffer (key/data store with 2-bit per-entry data control NONE/LOAD/INCR/CLR) between NUM_REQ requesters. Each requester submits {op, key, data} over a 4-phase req/ack handshake. The arbiter grants round-robin, drives the buffer ports for exactly one cycle, and captures the buffer's combinational data_out/valid into a registered response. It sits between client logic and the buffer instance; it is the only driver of the buffer's ctrl/key/data_in.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_SIZE, 4, key width; must match the buffer
DATA_SIZE, 4, data width; must match the buffer

Ports:
clk  input  1  system clock, all logic on rising edge
sync_nreset  input  1  synchronous active-low reset, sampled on rising clk
req  input  NUM_REQ  per-requester request, bit i = requester i
req_op  input  2*NUM_REQ  per-requester op, slice [2i+1:2i]: 0 NONE, 1 LOAD, 2 INCR, 3 CLR
req_key  input  KEY_SIZE*NUM_REQ  per-requester key, slice i
req_data  input  DATA_SIZE*NUM_REQ  per-requester data for LOAD, slice i
ack  output  NUM_REQ  one-hot acknowledge, held until the granted req drops
rsp_data  output  DATA_SIZE  buffer data_out before update; valid while ack is high
rsp_hit  output  1  key was present before the op; valid while ack is high
busy  output  1  state is not IDLE
buf_ctrl  output  2  to buffer ctrl
buf_key  output  KEY_SIZE  to buffer key
buf_data_in  output  DATA_SIZE  to buffer data_in
buf_data_out  input  DATA_SIZE  from buffer data_out (combinational)
buf_valid  input  1  from buffer valid (combinational hit)

Behaviour:
- Reset is synchronous. When sync_nreset=0 at a rising edge: state=IDLE, ack=0, rsp_data=0, rsp_hit=0, busy=0, buf_ctrl=NONE, buf_key=0, buf_data_in=0, rr pointer=NUM_REQ-1, so requester 0 has first priority. Reset mid-transaction aborts it with no ack. A buffer op already issued in ISSUE is not undone.
- All buffer-side outputs are registered.
- FSM with 3 states:
  - IDLE: buf_ctrl=NONE; buf_key/buf_data_in keep their last values, so the buffer sees no new key and allocates nothing. If any req bit is set, grant the first set bit searching from ptr+1, wrapping modulo NUM_REQ. Latch g, op, key and data. Load buf_ctrl/buf_key/buf_data_in with them and go to ISSUE.
  - ISSUE: exactly one cycle with the op on the buffer. At the end of the cycle: rsp_data <= buf_hit ? buf_data_out : 0; rsp_hit <= buf_valid; ack[g] <= 1; ptr <= g; buf_ctrl <= NONE; go to RESPOND.
  - RESPOND: hold ack[g] and the response. When req[g]=0, set ack to 0 and go to IDLE.
- Latency: req rises in cycle t; ack is high from t+2. Minimum cycle time per transaction is 4 clocks, including the IDLE cycle after req drops.
- Requesters must hold req and payload stable until ack. Payload changes after the grant edge are ignored. Other requesters' req bits are ignored outside IDLE.
- Miss with a full buffer: the buffer drops the op. rsp_hit=0, rsp_data=0, ack is still given.
- Miss with space free: the buffer allocates the key with op applied. rsp_hit=0, rsp_data=0.
- NONE op: acts as a lookup only. It allocates on a miss, per buffer semantics.
- The key driven while idle is the last issued key, or 0 after reset. The buffer may allocate key 0 after reset; this is buffer behaviour and outside this block's contract.
- busy=1 in ISSUE and RESPOND.

Decomposition:
- Package assoc_ctrl_pkg: op codes NONE=0, LOAD=1, INCR=2, CLR=3; state encoding IDLE/ISSUE/RESPOND.
- Sub-module rr_arbiter (params N): inputs req and ptr; outputs one-hot grant and grant index plus any_req. Purely combinational; the pointer lives in the top level.

Test Plan:
- Reset: hold sync_nreset=0 two cycles with req=4'b1111 -> ack=0, busy=0, buf_ctrl=0, rsp_*=0. Deassert -> requester 0 acked first, ack=4'b0001 two cycles after the release edge.
- Single LOAD then hit: req0 LOAD key 3 data 5 -> ack0 at t+2, rsp_hit=0. Then req0 NONE key 3 -> rsp_hit=1, rsp_data=5.
- INCR/CLR: after LOAD key 3=5, INCR key 3 -> rsp_data=5; NONE key 3 -> rsp_data=6. CLR key 3 -> rsp_data=6; NONE -> rsp_data=0.
- Round-robin fairness: req=4'b1011 held continuously, each req re-raised one cycle after its ack drops -> grant order 0,1,3,0,1,3. Requester 2 is never acked. buf_ctrl is non-NONE exactly one cycle per grant.
- Full buffer (BUFFER_SIZE 4): load keys 1..4, then LOAD key 9 -> rsp_hit=0, rsp_data=0. Lookups of 1..4 are still hits with their data.
- Handshake stall: hold req1 high 10 cycles after ack1 -> ack1 stays high, busy=1, no other grant. Meanwhile req2 is pending and is granted only after req1 drops.
